// File: rtl/array_serializer_tx.sv
// array_serializer_tx: frame serializer. It captures N words of W bits in one
// valid/ready handshake and sends them as a 1-bit valid/ready stream, MSB first,
// starting with word 0.
// Optional feature: define ARRAY_SERIALIZER_TX_PARITY_EN to append one even-parity
// bit to every frame. That bit carries s_last instead of the last data bit.
//
// Handshake rules (both ports): a beat moves on a rising edge where valid && ready.
// Once s_valid is asserted, s_valid, s_data and s_last hold stable until the beat
// moves. The only exception is abort, which withdraws s_valid.
// in_ready is combinational: it is high in IDLE, except while abort is high.
module array_serializer_tx #(
  parameter int W = 10,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data [0:N-1],
  input  logic         abort,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         s_data,
  output logic         s_last,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int WW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] BIT_MAX  = BW'(W - 1);
  localparam logic [WW-1:0] WORD_MAX = WW'(N - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic [1:0]    state;
  logic [W-1:0]  frame [0:N-1];
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic [W-1:0]  cur_word;
  logic          last_data;
  logic          xfer;

`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
  logic par_q;
  logic par_in;

  // Even parity over the whole incoming frame. It is latched at capture so the
  // parity bit never depends on in_data after the handshake.
  always_comb begin
    par_in = 1'b0;
    for (int i = 0; i < N; i++) par_in = par_in ^ (^in_data[i]);
  end
`endif

  // Select the word being shifted and flag the final data bit of the frame.
  always_comb begin
    cur_word  = frame[word_cnt];
    last_data = (state == ST_SHIFT) && (word_cnt == WORD_MAX) && (bit_cnt == BIT_MAX);
    xfer      = s_valid && s_ready;
  end

  // Output decode. Every output comes from registered state; abort only gates in_ready.
  always_comb begin
    in_ready  = (state == ST_IDLE) && !abort;
    s_valid   = (state != ST_IDLE);
    busy      = (state != ST_IDLE);
    dbg_state = state;
    s_data    = 1'b0;
    s_last    = 1'b0;
    case (state)
      ST_SHIFT: begin
        s_data = cur_word[BIT_MAX - bit_cnt];
`ifndef ARRAY_SERIALIZER_TX_PARITY_EN
        s_last = last_data;
`endif
      end
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
      ST_PARITY: begin
        s_data = par_q;
        s_last = 1'b1;
      end
`endif
      default: begin
        s_data = 1'b0;
        s_last = 1'b0;
      end
    endcase
  end

  // Sequencer: capture, bit/word counting, end of frame and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      for (int i = 0; i < N; i++) frame[i] <= '0;
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else if (abort) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            frame    <= in_data;
            bit_cnt  <= '0;
            word_cnt <= '0;
            state    <= ST_SHIFT;
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
            par_q    <= par_in;
`endif
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            if (bit_cnt == BIT_MAX) begin
              bit_cnt <= '0;
              if (last_data) begin
                // Clear word_cnt instead of wrapping past the last word.
                word_cnt <= '0;
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
                state    <= ST_PARITY;
`else
                state    <= ST_IDLE;
`endif
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
        ST_PARITY: begin
          if (xfer) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_serializer_tx.sv
// Testbench for array_serializer_tx. The driver pushes the expected {last,data} beats
// into a queue. A monitor running on the falling edge pops one entry for every
// accepted beat and compares it with the DUT outputs.
module tb_array_serializer_tx;

  localparam int W = 10;
  localparam int N = 5;
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
  localparam int FLEN = N * W + 1;
`else
  localparam int FLEN = N * W;
`endif

  typedef logic [W-1:0] frame_t [0:N-1];

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  frame_t     in_data;
  logic       abort;
  logic       s_valid;
  logic       s_ready;
  logic       s_data;
  logic       s_last;
  logic       busy;
  logic [1:0] dbg_state;

  array_serializer_tx #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  // Monitor state shared with the stimulus process.
  int xfer_cnt    = 0;
  int frame_len   = 0;
  int frames_done = 0;
  int gap_cnt     = 0;
  int last_gap    = -1;
  int stalls      = 0;
  bit in_gap      = 0;
  bit check_after = 0;
  bit stall_pend  = 0;
  logic held_d, held_l;
  int ready_mode  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: MSB-first beats, word 0 first, plus an optional parity beat.
  task automatic push_frame(input frame_t f);
    logic p;
    p = 1'b0;
    for (int w = 0; w < N; w++) begin
      for (int b = W - 1; b >= 0; b--) begin
        p = p ^ f[w][b];
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
        exp_q.push_back({1'b0, f[w][b]});
`else
        exp_q.push_back({(w == N - 1 && b == 0) ? 1'b1 : 1'b0, f[w][b]});
`endif
      end
    end
`ifdef ARRAY_SERIALIZER_TX_PARITY_EN
    exp_q.push_back({1'b1, p});
`endif
  endtask

  // Driver: present a frame, wait (bounded) for in_ready, and handshake.
  task automatic send_frame(input frame_t f, input bit keep);
    bit ok;
    ok = 0;
    in_data  = f;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("handshake_timeout", 0, 1);
    else push_frame(f);
    @(posedge clk); #2;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_xfer(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (xfer_cnt == n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_xfer_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !s_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  // Sink ready driver: always ready, or the repeating pattern 1,0,0,1.
  initial begin
    int cyc;
    cyc = 0;
    s_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (ready_mode == 0) s_ready = 1'b1;
      else s_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    end
  end

  // Scoreboard monitor. A beat moves on the next rising edge iff s_valid && s_ready && !abort.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      xfer_cnt    = 0;
      in_gap      = 0;
      check_after = 0;
      stall_pend  = 0;
    end else begin
      check("busy_eq_valid", busy, s_valid);
      check("in_ready_rule", in_ready, !s_valid && !abort);
      if (stall_pend) begin
        check("stall_valid_hold", s_valid, 1);
        check("stall_data_hold", s_data, held_d);
        check("stall_last_hold", s_last, held_l);
      end
      if (check_after) begin
        check("post_last_valid", s_valid, 0);
        check("post_last_in_ready", in_ready, 1);
        check_after = 0;
      end
      if (in_gap) begin
        if (!s_valid) gap_cnt++;
        else begin
          last_gap = gap_cnt;
          in_gap   = 0;
        end
      end
      stall_pend = s_valid && !s_ready && !abort;
      held_d = s_data;
      held_l = s_last;
      if (stall_pend) stalls++;
      if (abort) begin
        xfer_cnt = 0;
      end else if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("s_data", s_data, e[0]);
          check("s_last", s_last, e[1]);
        end
        xfer_cnt++;
        if (s_last) begin
          frame_len   = xfer_cnt;
          xfer_cnt    = 0;
          frames_done++;
          gap_cnt     = 0;
          in_gap      = 1;
          check_after = 1;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    frame_t f1, f2, fp;
    int fd;
    f1 = '{10'h3FF, 10'h000, 10'h2AA, 10'h155, 10'h001};
    f2 = '{10'h123, 10'h3C5, 10'h0F0, 10'h2B4, 10'h3FE};
    fp = '{10'h001, 10'h000, 10'h000, 10'h000, 10'h000};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = '{default: '0};

    // Reset values.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_s_valid", s_valid, 0);
    check("rst_s_data", s_data, 0);
    check("rst_s_last", s_last, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Reset in the middle of a frame.
    send_frame(f1, 0);
    wait_xfer(7);
    rst_n = 1'b0;
    #1;
    check("midrst_s_valid", s_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_s_last", s_last, 0);
    check("midrst_s_data", s_data, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    check("postrst_s_valid", s_valid, 0);
    @(posedge clk); #2;

    // Single frame with the sink always ready.
    send_frame(f1, 0);
    wait_idle();
    check("single_len", frame_len, FLEN);

    // Same frame under backpressure.
    ready_mode = 1;
    stalls = 0;
    send_frame(f1, 0);
    wait_idle();
    ready_mode = 0;
    check("bp_len", frame_len, FLEN);
    check("bp_saw_stalls", stalls > 10, 1);

    // Back-to-back frames with in_valid held high.
    fd = frames_done;
    send_frame(f1, 1);
    send_frame(f2, 0);
    wait_idle();
    check("b2b_frames", frames_done - fd, 2);
    check("b2b_gap", last_gap, 1);
    check("b2b_len", frame_len, FLEN);

    // Abort while beat 23 is presented, with a competing frame on the input.
    send_frame(f1, 0);
    wait_xfer(22);
    abort    = 1'b1;
    in_data  = f2;
    in_valid = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #2;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_s_valid", s_valid, 0);
    check("abort_state", dbg_state, 0);
    @(posedge clk); #2;
    send_frame(f2, 0);
    wait_idle();
    check("post_abort_len", frame_len, FLEN);

    // Frame with an odd number of ones (exercises the parity beat when enabled).
    send_frame(fp, 0);
    wait_idle();
    check("odd_len", frame_len, FLEN);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/array_serializer_tx.md
Name: array_serializer_tx

Overview:
- Transmit end of the unpacked-array word interface: accepts one frame of N words, each W bits (default 5 x 10-bit, matching the `wire [9:0] a [0:4]` port style), via valid/ready.
- Serializes the frame onto a 1-bit valid/ready stream consumed by the matching deserializer.
- Sits between a parallel producer and a narrow serial link.

Parameters:
- W, 10, bits per word (>=1)
- N, 5, words per frame (>=1)

Ports:
- clk  input  1  clock; all logic rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  producer has a frame on in_data
- in_ready  output  1  block can accept a frame
- in_data  input  W x N, declared [W-1:0] in_data [0:N-1]  frame words; index 0 sent first
- abort  input  1  synchronous frame abort
- s_valid  output  1  s_data valid
- s_ready  input  1  sink accepts bit
- s_data  output  1  serial bit
- s_last  output  1  final bit of frame
- busy  output  1  frame in progress

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - in_ready=1, s_valid=0, s_data=0, s_last=0, busy=0.
  - Counters cleared; frame register cleared.
- Counters:
  - bit_cnt counts 0..W-1, width $clog2(W) (min 1).
  - word_cnt counts 0..N-1, width $clog2(N) (min 1).
- States: IDLE, SHIFT (plus PARITY when the feature is enabled).
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid && in_ready at a rising edge: capture all N words into the frame register, bit_cnt=0, word_cnt=0, go to SHIFT.
  - in_data is ignored after capture.
- SHIFT:
  - s_valid=1, busy=1, in_ready=0.
  - s_data = frame[word_cnt][W-1-bit_cnt], i.e. MSB first, word 0 first.
  - Latency: first bit is presented the cycle after the input handshake.
- Bit transfer happens only on s_valid && s_ready.
  - If bit_cnt==W-1: bit_cnt wraps to 0 and word_cnt increments.
  - Otherwise bit_cnt increments.
- s_ready low: s_valid, s_data and s_last hold stable (AXI-style; s_valid is never withdrawn without abort).
- s_last is high only while presenting the final bit of the frame.
  - Without parity: word_cnt==N-1 && bit_cnt==W-1.
- On transfer of the s_last bit: go to IDLE.
  - s_valid=0 and in_ready=1 on the next cycle.
  - One bubble between frames; the next frame can handshake that same cycle.
- Frame length: N*W transfers without parity, N*W+1 with parity.
- abort, synchronous, highest priority below reset:
  - In any state: next cycle IDLE, counters cleared, s_valid=0.
  - A frame handshake in the same cycle as abort is ignored (in_ready is forced 0 while abort=1).
- Edge cases:
  - W=1 or N=1 must work; N=1, W=1 yields a 1-transfer frame with s_last on the first bit.
  - Counters never exceed their max; no wrap past the last word.

Optional Feature:
- Macro: ARRAY_SERIALIZER_TX_PARITY_EN.
- Defined:
  - After the last data bit transfers, enter PARITY for one transfer.
  - s_data = even parity (XOR) of all N*W frame bits, computed at capture.
  - s_last is asserted only in PARITY, not on the last data bit.
  - abort and s_ready backpressure apply identically.
- Undefined:
  - No PARITY state and no parity logic.
  - s_last is on the last data bit.

Test Plan:
- Reset mid-frame: assert rst_n=0 after 7 bits of a frame -> outputs immediately at reset values; after release in_ready=1 and s_valid=0.
- Single frame, N=5, W=10, words {10'h3FF,10'h000,10'h2AA,10'h155,10'h001}, s_ready=1 -> 50 transfers: 10 ones, 10 zeros, 1010101010, 0101010101, 0000000001; s_last only on transfer 50; in_ready high 1 cycle after.
- Backpressure: same frame, s_ready toggling 1,0,0,1... -> s_data/s_last stable during stalls; sequence identical to the previous scenario; busy high throughout.
- Back-to-back: in_valid held high with two frames -> second handshake the cycle in_ready returns; exactly one idle cycle (s_valid=0) between frames.
- Abort: abort=1 for 1 cycle at transfer 23 while in_valid=1 -> s_valid=0 next cycle, no capture that cycle; a new frame then starts at word 0 bit MSB.
- Parity (macro defined): frame with an odd count of ones (e.g. word0=10'h001, rest 0) -> 51 transfers; transfer 51 s_data=1, s_last=1; transfer 50 s_last=0.
